// File: rtl/ofs_plat_host_chan_wr_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_wr_burst_arbiter_if
// Brief    : Avalon write channel (request + write response) used on both
//            the source and sink sides of the write burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ofs_plat_host_chan_wr_burst_arbiter_if #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int USER_WIDTH      = 8,
  parameter int BURST_CNT_WIDTH = 3
);
  logic                       write;
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic [USER_WIDTH-1:0]      user;
  logic                       waitrequest;
  logic                       writeresponsevalid;
  logic [USER_WIDTH-1:0]      writeresponseuser;

  // Issuer of write bursts
  modport master (
    output write, address, burstcount, writedata, byteenable, user,
    input  waitrequest, writeresponsevalid, writeresponseuser
  );

  // Consumer of write bursts
  modport slave (
    input  write, address, burstcount, writedata, byteenable, user,
    output waitrequest, writeresponsevalid, writeresponseuser
  );
endinterface
`default_nettype wire

// File: rtl/ofs_plat_host_chan_wr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_wr_burst_arbiter
// Brief    : Two-source round-robin arbiter for a host-memory Avalon write
//            channel. Bursts are atomic, tagged with a source ID in the user
//            MSB, responses are routed back by that ID, and each source is
//            capped at MAX_OUTSTANDING unacknowledged bursts.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_host_chan_wr_burst_arbiter #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int USER_WIDTH      = 8,
  parameter int BURST_CNT_WIDTH = 3,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic clk,
  input  logic reset,
  ofs_plat_host_chan_wr_burst_arbiter_if.slave  src_wr_0,
  ofs_plat_host_chan_wr_burst_arbiter_if.slave  src_wr_1,
  ofs_plat_host_chan_wr_burst_arbiter_if.master m_wr
);
  localparam int                         c_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_WIDTH-1:0]     c_MAX_CNT   = c_CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [c_CNT_WIDTH-1:0]     c_CNT_ONE   = c_CNT_WIDTH'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] c_BC_ONE    = BURST_CNT_WIDTH'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] c_BC_TWO    = BURST_CNT_WIDTH'(2);
  localparam logic [BURST_CNT_WIDTH-1:0] c_BC_FOUR   = BURST_CNT_WIDTH'(4);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,   // next accepted beat is an SOP
    ST_LOCKED   = 1'b1    // mid-burst, grant frozen on r_owner
  } state_t;

  state_t                     r_state, w_state_next;
  logic                       r_owner, w_owner_next;
  logic [BURST_CNT_WIDTH-1:0] r_beats_left, w_beats_left_next;
  logic                       r_rr_last, w_rr_last_next;
  logic [c_CNT_WIDTH-1:0]     r_out_cnt [2];
  logic [1:0]                 r_rsp_valid;
  logic [USER_WIDTH-1:0]      r_rsp_user;

  logic [1:0]                 w_eligible;
  logic                       w_grant;
  logic                       w_grant_valid;
  logic                       w_accept;
  logic                       w_sop;
  logic [BURST_CNT_WIDTH-1:0] w_sop_bc;
  logic                       w_bc_legal;
  logic [BURST_CNT_WIDTH-1:0] w_sop_bc_eff;
  logic                       w_rsp_dest;
  logic [1:0]                 w_cnt_inc;
  logic [1:0]                 w_cnt_dec;

  assign w_eligible[0] = src_wr_0.write && (r_out_cnt[0] < c_MAX_CNT);
  assign w_eligible[1] = src_wr_1.write && (r_out_cnt[1] < c_MAX_CNT);

  // Grant selection: frozen on the owner while locked, round-robin on ties otherwise
  always_comb begin
    w_grant       = r_owner;
    w_grant_valid = 1'b1;
    if (r_state == ST_UNLOCKED) begin
      w_grant = 1'b0;
      if (w_eligible == 2'b11) begin
        w_grant = ~r_rr_last;
      end else if (w_eligible[1]) begin
        w_grant = 1'b1;
      end else if (!w_eligible[0]) begin
        w_grant_valid = 1'b0;
      end
    end
  end

  // Request path is a pure mux: zero-cycle latency, waitrequest passes through
  assign m_wr.write      = w_grant_valid && (w_grant ? src_wr_1.write : src_wr_0.write);
  assign m_wr.address    = w_grant ? src_wr_1.address    : src_wr_0.address;
  assign m_wr.burstcount = w_grant ? src_wr_1.burstcount : src_wr_0.burstcount;
  assign m_wr.writedata  = w_grant ? src_wr_1.writedata  : src_wr_0.writedata;
  assign m_wr.byteenable = w_grant ? src_wr_1.byteenable : src_wr_0.byteenable;
  assign m_wr.user       = {w_grant, (w_grant ? src_wr_1.user : src_wr_0.user)};

  assign src_wr_0.waitrequest = m_wr.waitrequest || !(w_grant_valid && !w_grant);
  assign src_wr_1.waitrequest = m_wr.waitrequest || !(w_grant_valid &&  w_grant);

  assign w_accept = m_wr.write && !m_wr.waitrequest;
  assign w_sop    = (r_state == ST_UNLOCKED);

  // Illegal burst counts (0, 3, >4) degrade to single-line bursts
  assign w_sop_bc     = m_wr.burstcount;
  assign w_bc_legal   = (w_sop_bc == c_BC_ONE) || (w_sop_bc == c_BC_TWO) || (w_sop_bc == c_BC_FOUR);
  assign w_sop_bc_eff = w_bc_legal ? w_sop_bc : c_BC_ONE;

  // Burst lock / round-robin next state
  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_beats_left_next = r_beats_left;
    w_rr_last_next    = r_rr_last;
    if (w_accept) begin
      if (w_sop) begin
        w_rr_last_next = w_grant;
        if (w_sop_bc_eff != c_BC_ONE) begin
          w_state_next      = ST_LOCKED;
          w_owner_next      = w_grant;
          w_beats_left_next = w_sop_bc_eff - c_BC_ONE;
        end
      end else begin
        w_beats_left_next = r_beats_left - c_BC_ONE;
        if (r_beats_left == c_BC_ONE) begin
          w_state_next = ST_UNLOCKED;
        end
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_UNLOCKED;
      r_owner      <= 1'b0;
      r_beats_left <= '0;
      r_rr_last    <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_beats_left <= w_beats_left_next;
      r_rr_last    <= w_rr_last_next;
    end
  end

  assign w_rsp_dest = m_wr.writeresponseuser[USER_WIDTH];

  // Per-source counter events: SOP accepts add, routed responses remove
  always_comb begin
    w_cnt_inc = 2'b00;
    w_cnt_dec = 2'b00;
    if (w_accept && w_sop) begin
      w_cnt_inc[w_grant] = 1'b1;
    end
    if (m_wr.writeresponsevalid) begin
      w_cnt_dec[w_rsp_dest] = 1'b1;
    end
  end

  // Outstanding-burst counters; a same-cycle add and remove cancel out
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        r_out_cnt[s] <= '0;
      end else if (w_cnt_inc[s] && !w_cnt_dec[s]) begin
        r_out_cnt[s] <= r_out_cnt[s] + c_CNT_ONE;
      end else if (w_cnt_dec[s] && !w_cnt_inc[s]) begin
        r_out_cnt[s] <= r_out_cnt[s] - c_CNT_ONE;
      end
    end
  end

  // Registered response steering by the echoed source ID
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 2'b00;
      r_rsp_user  <= '0;
    end else begin
      r_rsp_valid <= w_cnt_dec;
      r_rsp_user  <= m_wr.writeresponseuser[USER_WIDTH-1:0];
    end
  end

  assign src_wr_0.writeresponsevalid = r_rsp_valid[0];
  assign src_wr_1.writeresponsevalid = r_rsp_valid[1];
  assign src_wr_0.writeresponseuser  = r_rsp_user;
  assign src_wr_1.writeresponseuser  = r_rsp_user;

`ifndef SYNTHESIS
  // Protocol violations that would corrupt the lock or the counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_accept && w_sop && !w_bc_legal) begin
        $fatal(1, "wr_burst_arbiter: illegal burstcount %0d", w_sop_bc);
      end
      if (m_wr.writeresponsevalid && (r_out_cnt[w_rsp_dest] == '0)) begin
        $fatal(1, "wr_burst_arbiter: response to source %0d with nothing outstanding", w_rsp_dest);
      end
    end
  end
`endif

endmodule
`default_nettype wire
